// File: rtl/switch_pkg.sv
// Shared types for the switch destination lookup: FSM encoding, MAC width and
// forwarding-table entry layout.
package switch_pkg;
  localparam int MAC_W     = 48;
  // Entry masks are stored at the widest supported radix; instances use the low RADIX bits.
  localparam int MAX_RADIX = 32;

  typedef enum logic [1:0] {IDLE, LOOKUP, FWD, DROP} sw_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MAC_W-1:0]     mac;
    logic [MAX_RADIX-1:0] mask;
  } fwd_entry_t;
endpackage

// File: rtl/switch_fwd_table.sv
// Forwarding table: register storage, single write port, parallel DMAC match and
// lowest-index priority select. Lookups see contents as of the start of the cycle.
module switch_fwd_table
  import switch_pkg::*;
#(
  parameter int RADIX       = 4,
  parameter int TABLE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en_i,
  input  logic [$clog2(TABLE_DEPTH)-1:0] wr_addr_i,
  input  logic                           wr_valid_i,
  input  logic [MAC_W-1:0]               wr_mac_i,
  input  logic [RADIX-1:0]               wr_mask_i,
  input  logic [MAC_W-1:0]               mac_i,
  output logic                           hit_o,
  output logic [RADIX-1:0]               mask_o
);
  fwd_entry_t [TABLE_DEPTH-1:0] ent_q;
  logic [TABLE_DEPTH-1:0]       match;
  logic [MAX_RADIX-1:0]         mask_or;
  logic                         unused_mask;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ent_q <= '0;
    else if (wr_en_i)
      ent_q[wr_addr_i] <= '{valid: wr_valid_i, mac: wr_mac_i, mask: MAX_RADIX'(wr_mask_i)};

  for (genvar i = 0; i < TABLE_DEPTH; i++) begin : g_match
    assign match[i] = ent_q[i].valid && (ent_q[i].mac == mac_i);
  end

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit_o  = 1'b0;
    mask_o = '0;
    for (int i = TABLE_DEPTH-1; i >= 0; i--)
      if (match[i]) begin
        hit_o  = 1'b1;
        mask_o = ent_q[i].mask[RADIX-1:0];
      end
  end

  always_comb begin
    mask_or = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) mask_or |= ent_q[i].mask;
  end
  assign unused_mask = ^mask_or;
endmodule

// File: rtl/switch_dest_lookup.sv
// Ingress destination lookup: holds the first beat, resolves the output-port mask
// from the DMAC, then forwards or drops the packet. SWITCH_DEST_LOOKUP_STATS_EN adds counters.
module switch_dest_lookup
  import switch_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int AXIS_ID_WIDTH   = 8,
  parameter int AXIS_USER_WIDTH = 17,
  parameter int RADIX           = 4,
  parameter int SRC_PORT        = 0,
  parameter int TABLE_DEPTH     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef SWITCH_DEST_LOOKUP_STATS_EN
  output logic [31:0]                    stat_hit,
  output logic [31:0]                    stat_miss,
  output logic [31:0]                    stat_drop,
`endif
  input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]     s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [AXIS_ID_WIDTH-1:0]       s_axis_tid,
  input  logic [AXIS_USER_WIDTH-1:0]     s_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]     m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [AXIS_ID_WIDTH-1:0]       m_axis_tid,
  output logic [AXIS_USER_WIDTH-1:0]     m_axis_tuser,
  output logic [RADIX-1:0]               m_axis_tdest,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(TABLE_DEPTH)-1:0] cfg_wr_addr,
  input  logic                           cfg_wr_valid,
  input  logic [MAC_W-1:0]               cfg_wr_mac,
  input  logic [RADIX-1:0]               cfg_wr_mask
);
  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic [AXIS_KEEP_WIDTH-1:0] keep;
    logic                       last;
    logic [AXIS_ID_WIDTH-1:0]   id;
    logic [AXIS_USER_WIDTH-1:0] user;
  } beat_t;

  sw_state_e        state_q;
  beat_t            s_beat, hold_q, out_q;
  logic             out_vld_q, in_done_q;
  logic [RADIX-1:0] tdest_q, tbl_mask, res_mask;
  logic             tbl_hit, grp, s_rdy, s_hs, m_hs;

  assign s_beat = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast,
                    id: s_axis_tid, user: s_axis_tuser};
  assign grp    = hold_q.data[0];

  switch_fwd_table #(.RADIX(RADIX), .TABLE_DEPTH(TABLE_DEPTH)) u_tbl (
    .clk, .rst_n,
    .wr_en_i(cfg_wr_en), .wr_addr_i(cfg_wr_addr), .wr_valid_i(cfg_wr_valid),
    .wr_mac_i(cfg_wr_mac), .wr_mask_i(cfg_wr_mask),
    .mac_i(hold_q.data[MAC_W-1:0]), .hit_o(tbl_hit), .mask_o(tbl_mask)
  );

  always_comb begin
    res_mask           = (grp || !tbl_hit) ? '1 : tbl_mask;
    res_mask[SRC_PORT] = 1'b0;
  end

  // Once the input tlast is taken, stall ingress so the next packet's head waits for IDLE.
  always_comb begin
    s_rdy = 1'b0;
    case (state_q)
      IDLE:    s_rdy = 1'b1;
      FWD:     s_rdy = !in_done_q && (m_axis_tready || !out_vld_q);
      DROP:    s_rdy = 1'b1;
      default: s_rdy = 1'b0;
    endcase
  end

  assign s_axis_tready = s_rdy & rst_n;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = out_vld_q & m_axis_tready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      in_done_q <= 1'b0;
      tdest_q   <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (s_hs) begin
            hold_q  <= s_beat;
            state_q <= LOOKUP;
          end
        LOOKUP: begin
          in_done_q <= hold_q.last;
          if (res_mask == '0) state_q <= hold_q.last ? IDLE : DROP;
          else begin
            state_q   <= FWD;
            tdest_q   <= res_mask;
            out_q     <= hold_q;
            out_vld_q <= 1'b1;
          end
        end
        FWD: begin
          if (s_hs) begin
            out_q     <= s_beat;
            out_vld_q <= 1'b1;
            if (s_axis_tlast) in_done_q <= 1'b1;
          end else if (m_hs) out_vld_q <= 1'b0;
          if (m_hs && out_q.last) state_q <= IDLE;
        end
        DROP:
          if (s_hs && s_axis_tlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end

  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tid    = out_q.id;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdest  = tdest_q;

`ifdef SWITCH_DEST_LOOKUP_STATS_EN
  logic [31:0] hit_q, miss_q, drop_q;

  // Group-addressed packets count as misses even when an entry matches.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
      drop_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (tbl_hit && !grp) hit_q <= hit_q + 32'd1;
      else                 miss_q <= miss_q + 32'd1;
      if (res_mask == '0)  drop_q <= drop_q + 32'd1;
    end

  assign stat_hit  = hit_q;
  assign stat_miss = miss_q;
  assign stat_drop = drop_q;
`endif
endmodule

// File: tb/tb_switch_dest_lookup.sv
// Bench for switch_dest_lookup: directed cases plus randomized packets checked
// against a packet-level reference model of the forwarding rules.
module tb_switch_dest_lookup;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [63:0] s_tdata = '0, m_tdata;
  logic [7:0]  s_tkeep = '0, m_tkeep, s_tid = '0, m_tid;
  logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic        m_tvalid, m_tready = 1'b1, m_tlast;
  logic [16:0] s_tuser = '0, m_tuser;
  logic [3:0]  m_tdest;
  logic        cfg_wr_en = 1'b0, cfg_wr_valid = 1'b0;
  logic [2:0]  cfg_wr_addr = '0;
  logic [47:0] cfg_wr_mac = '0;
  logic [3:0]  cfg_wr_mask = '0;
`ifdef SWITCH_DEST_LOOKUP_STATS_EN
  logic [31:0] stat_hit, stat_miss, stat_drop;
`endif

  switch_dest_lookup dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SWITCH_DEST_LOOKUP_STATS_EN
    .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_drop(stat_drop),
`endif
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tuser(m_tuser),
    .m_axis_tdest(m_tdest),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_valid(cfg_wr_valid),
    .cfg_wr_mac(cfg_wr_mac), .cfg_wr_mask(cfg_wr_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d; logic [7:0] k; logic l; logic [7:0] id; logic [16:0] u; logic [3:0] dest;
  } exp_t;

  int          n_cmp = 0, n_bad = 0, cyc = 0, out_cnt = 0, lat_last = 0, first_hs_cyc = 0;
  int          rdy_mode = 0;
  exp_t        exp_q[$];
  logic        mv[8];
  logic [47:0] mmac[8];
  logic [3:0]  mmask[8];
  logic        in_pkt = 1'b0, prev_v = 1'b0, stall_pend = 1'b0;
  logic [3:0]  cur_mask = '0, last_dest = '0;
  logic [68:0] stall_snap = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Forwarding rule: group or unknown DMAC floods, else lowest matching entry; own port never.
  function automatic logic [3:0] model_mask(input logic [47:0] mac);
    logic [3:0] m;
    logic       found;
    m = 4'hF;
    found = 1'b0;
    if (!mac[0])
      for (int i = 0; i < 8; i++)
        if (!found && mv[i] && mmac[i] == mac) begin
          m = mmask[i];
          found = 1'b1;
        end
    m[0] = 1'b0;
    return m;
  endfunction

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_pend) begin
        chk("hold_valid", 128'(m_tvalid), 128'd1);
        chk("hold_data", 128'({m_tdata, m_tlast, m_tdest}), 128'(stall_snap));
      end
      if (m_tvalid && !prev_v) lat_last = cyc - first_hs_cyc;
      prev_v = m_tvalid;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got data %0h dest %0h want none", m_tdata, m_tdest);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 128'({m_tdata, m_tkeep, m_tlast, m_tid, m_tuser, m_tdest}), 128'(e));
        end
        out_cnt++;
        last_dest = m_tdest;
      end
      stall_pend = m_tvalid && !m_tready;
      stall_snap = {m_tdata, m_tlast, m_tdest};
      if (s_tvalid && s_tready) begin
        if (!in_pkt) begin
          cur_mask = model_mask(s_tdata[47:0]);
          first_hs_cyc = cyc;
        end
        if (cur_mask != 4'd0) exp_q.push_back({s_tdata, s_tkeep, s_tlast, s_tid, s_tuser, cur_mask});
        in_pkt = !s_tlast;
      end
    end else begin
      prev_v = 1'b0;
      stall_pend = 1'b0;
    end
  end

  task automatic tbl_wr(input int a, input logic v, input logic [47:0] mac, input logic [3:0] mask);
    cfg_wr_en = 1'b1; cfg_wr_addr = a[2:0]; cfg_wr_valid = v; cfg_wr_mac = mac; cfg_wr_mask = mask;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    mv[a] = v; mmac[a] = mac; mmask[a] = mask;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic l);
    int   t;
    logic rdy;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    s_tkeep = 8'($urandom); s_tid = 8'($urandom); s_tuser = 17'($urandom);
    t = 0; rdy = 1'b0;
    while (!rdy && t < 300) begin
      @(negedge clk); rdy = s_tready;
      @(posedge clk); #1; t++;
    end
    s_tvalid = 1'b0;
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL s_timeout: got no tready want handshake");
    end
  endtask

  task automatic send_pkt(input logic [47:0] mac, input int n, input logic gaps);
    logic [63:0] d;
    for (int b = 0; b < n; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = {$urandom, $urandom};
      if (b == 0) d[47:0] = mac;
      drive_beat(d, b == n-1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin @(posedge clk); t++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d beats pending want 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  localparam logic [47:0] MAC5  = 48'h05_00_00_00_00_02;
  localparam logic [47:0] MACD  = 48'h11_22_33_44_55_66;
  localparam logic [47:0] MACP  = 48'h0a_0b_0c_0d_0e_10;
  localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;

  initial begin
    int          o, t;
    logic [47:0] pool[8];
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; mmac[i] = '0; mmask[i] = '0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 128'(s_tready), 128'd0);
    chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
    chk("rst_m_tdest", 128'(m_tdest), 128'd0);
`ifdef SWITCH_DEST_LOOKUP_STATS_EN
    chk("rst_stats", 128'({stat_hit, stat_miss, stat_drop}), 128'd0);
`endif
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Unicast hit, 3 beats, two-cycle head latency
    tbl_wr(2, 1'b1, MAC5, 4'b0100);
    o = out_cnt;
    send_pkt(MAC5, 3, 1'b0);
    drain();
    chk("uc_beats", 128'(out_cnt - o), 128'd3);
    chk("uc_dest", 128'(last_dest), 128'b0100);
    chk("uc_latency", 128'(lat_last), 128'd2);

    send_pkt(BCAST, 2, 1'b0);
    drain();
    chk("bcast_dest", 128'(last_dest), 128'b1110);

    // Own-port-only mask drops, both multi-beat and single-beat
    tbl_wr(4, 1'b1, MACD, 4'b0001);
    o = out_cnt;
    send_pkt(MACD, 3, 1'b0);
    drain();
    chk("drop_beats", 128'(out_cnt - o), 128'd0);
`ifdef SWITCH_DEST_LOOKUP_STATS_EN
    chk("drop_stat", 128'(stat_drop), 128'd1);
`endif
    send_pkt(MACD, 1, 1'b0);
    drain();
    chk("drop1_beats", 128'(out_cnt - o), 128'd0);

    tbl_wr(1, 1'b1, MACP, 4'b0010);
    tbl_wr(3, 1'b1, MACP, 4'b1000);
    send_pkt(MACP, 2, 1'b0);
    drain();
    chk("prio_dest", 128'(last_dest), 128'b0010);

    // Backpressure for five cycles mid-packet
    o = out_cnt;
    fork
      send_pkt(MAC5, 4, 1'b0);
      begin
        t = 0;
        while (out_cnt == o && t < 100) begin @(posedge clk); t++; end
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();
    chk("stall_beats", 128'(out_cnt - o), 128'd4);

    // Reset during beat 2 of 4
    drive_beat({16'h0, MAC5}, 1'b0);
    drive_beat({$urandom, $urandom}, 1'b0);
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    exp_q.delete();
    in_pkt = 1'b0;
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_tvalid", 128'(m_tvalid), 128'd0);
    chk("mid_rst_m_tdest", 128'(m_tdest), 128'd0);
    chk("mid_rst_s_tready", 128'(s_tready), 128'd0);
`ifdef SWITCH_DEST_LOOKUP_STATS_EN
    chk("mid_rst_stat_hit", 128'(stat_hit), 128'd0);
`endif
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    o = out_cnt;
    send_pkt(MAC5, 2, 1'b0);
    drain();
    chk("post_rst_flood", 128'(last_dest), 128'b1110);
    tbl_wr(2, 1'b1, MAC5, 4'b0100);
    send_pkt(MAC5, 3, 1'b0);
    drain();
    chk("post_rst_dest", 128'(last_dest), 128'b0100);
    chk("post_rst_beats", 128'(out_cnt - o), 128'd5);

    // Randomized traffic with table churn and random backpressure
    for (int i = 0; i < 6; i++) pool[i] = {$urandom, 16'($urandom)} & ~48'h1;
    pool[6] = BCAST;
    pool[7] = {$urandom, 16'($urandom)} | 48'h1;
    for (int i = 0; i < 8; i++)
      tbl_wr(i, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 4'($urandom));
    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      if (p % 5 == 4)
        tbl_wr($urandom_range(0, 7), 1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 7)], 4'($urandom));
      send_pkt(($urandom_range(0, 9) == 0) ? {$urandom, 16'($urandom)} : pool[$urandom_range(0, 7)],
               $urandom_range(1, 5), 1'b1);
    end
    drain();
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/switch_dest_lookup.md
SWITCH_DEST_LOOKUP -- requirements
Module: switch_dest_lookup

Interface
REQ-001 Parameter AXIS_DATA_WIDTH, default 64, data bus width in bits; SHALL be at least 64.
REQ-002 Parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, keep width.
REQ-003 Parameter AXIS_ID_WIDTH, default 8, id width; AXIS_USER_WIDTH, default 17, user width.
REQ-004 Parameter RADIX, default 4, switch port count; the output tdest width equals RADIX (one-hot or multi-hot output-port mask).
REQ-005 Parameter SRC_PORT, default 0, index of the ingress port this instance serves.
REQ-006 Parameter TABLE_DEPTH, default 8, number of forwarding entries; SHALL be a power of two.
REQ-007 Port clk  in  1  single clock for all logic.
REQ-008 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 Ports s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tuser  in (tready out)  AXIS widths  ingress packet stream, no tdest.
REQ-010 Ports m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tuser  out (tready in)  AXIS widths  stream toward crossbar.
REQ-011 Port m_axis_tdest  out  RADIX  output-port mask, held constant for every beat of a packet.
REQ-012 Ports cfg_wr_en (1), cfg_wr_addr ($clog2(TABLE_DEPTH)), cfg_wr_valid (1), cfg_wr_mac (48), cfg_wr_mask (RADIX)  in  table write port.

Function
REQ-013 DMAC SHALL be tdata[47:0] of the first beat, byte 0 in tdata[7:0]; group bit = tdata[0].
REQ-014 FSM states: IDLE, LOOKUP, FWD, DROP.
REQ-015 IDLE: s_axis_tready=1; on a first-beat handshake, capture the beat into the hold register and go to LOOKUP.
REQ-016 LOOKUP: s_axis_tready=0; compare the DMAC against all valid entries in parallel; register the mask; go to FWD, or to DROP if the resolved mask is zero, in exactly one cycle.
REQ-017 Mask resolution: group bit set, or no hit -> flood = all ones with bit SRC_PORT cleared; hit -> mask of the lowest-index matching entry, with bit SRC_PORT cleared.
REQ-018 FWD: the output register drives beats; s_axis_tready = m_axis_tready | ~m_axis_tvalid; full-throughput pass-through after the first beat.
REQ-019 FWD: return to IDLE when the tlast beat is accepted on the output; a single-beat packet returns after its one output handshake.
REQ-020 DROP: m_axis_tvalid=0 and s_axis_tready=1; consume beats to tlast, then go to IDLE; if the captured first beat already had tlast, go to IDLE directly.
REQ-021 First-beat latency: s handshake at cycle N -> m_axis_tvalid at cycle N+2.
REQ-022 m_axis_tvalid SHALL NOT drop and data SHALL NOT change while m_axis_tready=0.
REQ-023 A table write takes effect the next cycle; a write in the same cycle as LOOKUP is not seen by that lookup.
REQ-024 A simultaneous write to the entry being matched: the lookup uses the old contents.

Reset
REQ-025 Reset SHALL set: FSM=IDLE, all entry valid bits=0, m_axis_tvalid=0, m_axis_tdest=0, s_axis_tready=0 during reset, counters=0.
REQ-026 Reset mid-packet abandons the packet; after release, the next beat is treated as a first beat.

Configuration
REQ-027 Macro SWITCH_DEST_LOOKUP_STATS_EN defined: adds outputs stat_hit, stat_miss and stat_drop (32-bit each, wrap on overflow), each incremented once per packet at LOOKUP exit; group-addressed packets count as miss.
REQ-028 Macro undefined: those ports and counters SHALL be absent; behaviour is otherwise identical.

Structure
REQ-029 Shared package switch_pkg SHALL hold the FSM state encoding, the MAC width constant (48) and the table-entry typedef {valid, mac, mask}.
REQ-030 A sub-module switch_fwd_table (storage, write port, parallel match, priority encode) is natural; the FSM and datapath stay in the top.

Verification
REQ-031 Entry 2 = {MAC 02:00:00:00:00:05, mask 4'b0100}, SRC_PORT=0, send 3-beat packet to that MAC -> 3 beats out, tdest=4'b0100 on all, first beat 2 cycles after input.
REQ-032 Broadcast DMAC ff:ff:ff:ff:ff:ff -> tdest=4'b1110.
REQ-033 Entry mask 4'b0001 (own port only) -> packet dropped, no m_axis_tvalid, stat_drop=1.
REQ-034 Hold m_axis_tready=0 for 5 cycles mid-packet -> no beat lost or duplicated, data stable.
REQ-035 Assert rst_n=0 during beat 2 of 4 -> outputs reset; next packet forwarded correctly.
REQ-036 Two entries match the same MAC (indices 1 and 3) -> mask of index 1 used.
